// File: rtl/ahblite_decoder_mux.sv
// AHB-Lite address decoder and slave-response mux with a built-in ERROR default slave.
// Define AHB_DECERR_LOG_EN to enable the sticky decode-error flag and first-error address log.
module ahblite_decoder_mux #(
    parameter int                         NUM_SLV  = 4,
    parameter int                         TAG_W    = 4,
    parameter logic [NUM_SLV*TAG_W-1:0]   SLV_TAGS = 16'h4210
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    output logic                    HREADY,
    output logic                    HRESP,
    output logic [31:0]             HRDATA,
    output logic [NUM_SLV-1:0]      HSEL_S,
    input  logic [NUM_SLV-1:0]      HREADYOUT_S,
    input  logic [NUM_SLV-1:0]      HRESP_S,
    input  logic [NUM_SLV*32-1:0]   HRDATA_S,
    input  logic                    decerr_clr,
    output logic                    decerr_flag,
    output logic [31:0]             decerr_addr
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    localparam logic [1:0] DS_NONE = 2'd0;
    localparam logic [1:0] DS_SLV  = 2'd1;
    localparam logic [1:0] DS_DEF  = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic [IDX_W-1:0] w_idx;
    logic             w_err_start;

    logic [1:0]       r_dsel_kind;
    logic [IDX_W-1:0] r_dsel_idx;
    logic [1:0]       r_state;

    assign w_tag = HADDR[31 -: TAG_W];

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (w_tag == SLV_TAGS[i*TAG_W +: TAG_W]) begin
                w_hit = 1'b1;
                w_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        HSEL_S = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (w_hit && (w_idx == IDX_W'(i))) HSEL_S[i] = 1'b1;
        end
    end

    assign w_err_start = HREADY & HTRANS[1] & ~w_hit;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dsel_kind <= DS_NONE;
            r_dsel_idx  <= '0;
        end else if (HREADY) begin
            if (!HTRANS[1]) begin
                r_dsel_kind <= DS_NONE;
            end else if (w_hit) begin
                r_dsel_kind <= DS_SLV;
                r_dsel_idx  <= w_idx;
            end else begin
                r_dsel_kind <= DS_DEF;
            end
        end
    end

    // ERR1 always stalls, so only IDLE or ERR2 can observe w_err_start.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
        end else if (r_state == ST_ERR1) begin
            r_state <= ST_ERR2;
        end else if (w_err_start) begin
            r_state <= ST_ERR1;
        end else begin
            r_state <= ST_IDLE;
        end
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        case (r_dsel_kind)
            DS_SLV: begin
                for (int i = 0; i < NUM_SLV; i++) begin
                    if (r_dsel_idx == IDX_W'(i)) begin
                        HREADY = HREADYOUT_S[i];
                        HRESP  = HRESP_S[i];
                        HRDATA = HRDATA_S[i*32 +: 32];
                    end
                end
            end
            DS_DEF: begin
                HREADY = (r_state != ST_ERR1);
                HRESP  = (r_state != ST_IDLE);
            end
            default: ;
        endcase
    end

`ifdef AHB_DECERR_LOG_EN
    logic        r_decerr_flag;
    logic [31:0] r_decerr_addr;

    // A new error wins over a clear in the same cycle and re-arms the address capture.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_decerr_flag <= 1'b0;
            r_decerr_addr <= '0;
        end else if (w_err_start) begin
            r_decerr_flag <= 1'b1;
            if (!r_decerr_flag || decerr_clr) r_decerr_addr <= HADDR;
        end else if (decerr_clr) begin
            r_decerr_flag <= 1'b0;
            r_decerr_addr <= '0;
        end
    end

    assign decerr_flag = r_decerr_flag;
    assign decerr_addr = r_decerr_addr;
`else
    logic w_unused;
    assign w_unused    = ^{decerr_clr, HADDR};
    assign decerr_flag = 1'b0;
    assign decerr_addr = '0;
`endif

endmodule

// File: tb/tb_ahblite_decoder_mux.sv
// Directed bench for ahblite_decoder_mux: default map instance plus a duplicate-tag instance.
module tb_ahblite_decoder_mux;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HREADY, HRESP;
    logic [31:0] HRDATA;
    logic [3:0]  HSEL_S, HREADYOUT_S, HRESP_S;
    logic [127:0] HRDATA_S;
    logic        decerr_clr, decerr_flag;
    logic [31:0] decerr_addr;

    logic [31:0] HADDR2;
    logic [1:0]  HTRANS2;
    logic        HREADY2, HRESP2;
    logic [31:0] HRDATA2;
    logic [1:0]  HSEL_S2, HREADYOUT_S2, HRESP_S2;
    logic [63:0] HRDATA_S2;
    logic        decerr_flag2;
    logic [31:0] decerr_addr2;

    int n_pass  = 0;
    int n_total = 0;

`ifdef AHB_DECERR_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    always #5 HCLK = ~HCLK;

    ahblite_decoder_mux u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .HSEL_S(HSEL_S),
        .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
        .decerr_clr(decerr_clr), .decerr_flag(decerr_flag), .decerr_addr(decerr_addr)
    );

    ahblite_decoder_mux #(.NUM_SLV(2), .TAG_W(4), .SLV_TAGS(8'h00)) u_dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR2), .HTRANS(HTRANS2),
        .HREADY(HREADY2), .HRESP(HRESP2), .HRDATA(HRDATA2), .HSEL_S(HSEL_S2),
        .HREADYOUT_S(HREADYOUT_S2), .HRESP_S(HRESP_S2), .HRDATA_S(HRDATA_S2),
        .decerr_clr(1'b0), .decerr_flag(decerr_flag2), .decerr_addr(decerr_addr2)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic pulse_clr();
        decerr_clr = 1'b1;
        tick();
        decerr_clr = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; HADDR = '0; HTRANS = 2'b00; decerr_clr = 1'b0;
        HREADYOUT_S = 4'b1111; HRESP_S = 4'b0000;
        HRDATA_S = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        HADDR2 = '0; HTRANS2 = 2'b00; HREADYOUT_S2 = 2'b01; HRESP_S2 = 2'b10;
        HRDATA_S2 = {32'hBEEF_0001, 32'hCAFE_0000};
        #2;
        n_total++; if (HREADY !== 1'b1) $display("FAIL rst_hready: got %b want 1", HREADY); else n_pass++;
        n_total++; if (HRESP !== 1'b0) $display("FAIL rst_hresp: got %b want 0", HRESP); else n_pass++;
        n_total++; if (HRDATA !== 32'h0) $display("FAIL rst_hrdata: got %h want 0", HRDATA); else n_pass++;
        n_total++; if (decerr_flag !== 1'b0) $display("FAIL rst_flag: got %b want 0", decerr_flag); else n_pass++;
        n_total++; if (decerr_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", decerr_addr); else n_pass++;
        tick(); tick();
        HRESETn = 1'b1;
        tick();
    endtask

    task automatic test_idle_decode();
        HTRANS = 2'b00;
        HADDR = 32'h1000_0040; #1;
        n_total++; if (HSEL_S !== 4'b0010) $display("FAIL idle_hsel1: got %b want 0010", HSEL_S); else n_pass++;
        HADDR = 32'h4ABC_0000; #1;
        n_total++; if (HSEL_S !== 4'b1000) $display("FAIL idle_hsel4: got %b want 1000", HSEL_S); else n_pass++;
        HADDR = 32'h0000_0008; #1;
        n_total++; if (HSEL_S !== 4'b0001) $display("FAIL idle_hsel0: got %b want 0001", HSEL_S); else n_pass++;
        HADDR = 32'h3000_0000; #1;
        n_total++; if (HSEL_S !== 4'b0000) $display("FAIL idle_hsel_unmapped: got %b want 0000", HSEL_S); else n_pass++;
        tick();
        n_total++; if (HREADY !== 1'b1) $display("FAIL idle_hready: got %b want 1", HREADY); else n_pass++;
        n_total++; if (HRESP !== 1'b0) $display("FAIL idle_hresp: got %b want 0", HRESP); else n_pass++;
        n_total++; if (HRDATA !== 32'h0) $display("FAIL idle_hrdata: got %h want 0", HRDATA); else n_pass++;
    endtask

    task automatic test_slave_stall();
        HADDR = 32'h2000_0010; HTRANS = 2'b10; HREADYOUT_S = 4'b1011; #1;
        n_total++; if (HSEL_S !== 4'b0100) $display("FAIL stall_hsel: got %b want 0100", HSEL_S); else n_pass++;
        n_total++; if (HREADY !== 1'b1) $display("FAIL stall_addr_hready: got %b want 1", HREADY); else n_pass++;
        tick();
        HTRANS = 2'b00; HADDR = 32'h3000_0000; #1;
        for (int c = 1; c <= 3; c++) begin
            n_total++; if (HREADY !== 1'b0) $display("FAIL stall_wait%0d: got %b want 0", c, HREADY); else n_pass++;
            if (c < 3) tick();
        end
        tick();
        HREADYOUT_S = 4'b1111; HRDATA_S[2*32 +: 32] = 32'hA5A5_0001; #1;
        n_total++; if (HREADY !== 1'b1) $display("FAIL stall_done_hready: got %b want 1", HREADY); else n_pass++;
        n_total++; if (HRDATA !== 32'hA5A5_0001) $display("FAIL stall_rdata: got %h want a5a50001", HRDATA); else n_pass++;
        n_total++; if (HRESP !== 1'b0) $display("FAIL stall_hresp: got %b want 0", HRESP); else n_pass++;
        tick();
        n_total++; if (HRDATA !== 32'h0) $display("FAIL stall_after_rdata: got %h want 0", HRDATA); else n_pass++;
    endtask

    task automatic test_unmapped();
        HADDR = 32'h3000_0000; HTRANS = 2'b10; #1;
        n_total++; if (HREADY !== 1'b1) $display("FAIL unm_addr_hready: got %b want 1", HREADY); else n_pass++;
        tick();
        HTRANS = 2'b00; HADDR = 32'h0; #1;
        n_total++; if (HREADY !== 1'b0) $display("FAIL unm_err1_hready: got %b want 0", HREADY); else n_pass++;
        n_total++; if (HRESP !== 1'b1) $display("FAIL unm_err1_hresp: got %b want 1", HRESP); else n_pass++;
        n_total++; if (HRDATA !== 32'h0) $display("FAIL unm_err1_rdata: got %h want 0", HRDATA); else n_pass++;
        n_total++; if (decerr_flag !== LOG) $display("FAIL unm_flag: got %b want %b", decerr_flag, LOG); else n_pass++;
        n_total++; if (decerr_addr !== (LOG ? 32'h3000_0000 : 32'h0))
            $display("FAIL unm_addr: got %h want %h", decerr_addr, (LOG ? 32'h3000_0000 : 32'h0)); else n_pass++;
        tick();
        n_total++; if (HREADY !== 1'b1) $display("FAIL unm_err2_hready: got %b want 1", HREADY); else n_pass++;
        n_total++; if (HRESP !== 1'b1) $display("FAIL unm_err2_hresp: got %b want 1", HRESP); else n_pass++;
        tick();
        n_total++; if (HRESP !== 1'b0) $display("FAIL unm_idle_hresp: got %b want 0", HRESP); else n_pass++;
        n_total++; if (HREADY !== 1'b1) $display("FAIL unm_idle_hready: got %b want 1", HREADY); else n_pass++;
    endtask

    task automatic test_back_to_back(input bit clr2);
        logic [31:0] exp_addr;
        pulse_clr(); #1;
        n_total++; if (decerr_flag !== 1'b0) $display("FAIL b2b_clr_flag: got %b want 0", decerr_flag); else n_pass++;
        n_total++; if (decerr_addr !== 32'h0) $display("FAIL b2b_clr_addr: got %h want 0", decerr_addr); else n_pass++;
        HADDR = 32'h3000_0000; HTRANS = 2'b10;
        tick();
        HADDR = 32'h5000_0000; #1;
        n_total++; if (HREADY !== 1'b0 || HRESP !== 1'b1)
            $display("FAIL b2b_err1a: got ready=%b resp=%b want ready=0 resp=1", HREADY, HRESP); else n_pass++;
        tick();
        decerr_clr = clr2; #1;
        n_total++; if (HREADY !== 1'b1 || HRESP !== 1'b1)
            $display("FAIL b2b_err2a: got ready=%b resp=%b want ready=1 resp=1", HREADY, HRESP); else n_pass++;
        tick();
        decerr_clr = 1'b0; HTRANS = 2'b00; #1;
        n_total++; if (HREADY !== 1'b0 || HRESP !== 1'b1)
            $display("FAIL b2b_err1b: got ready=%b resp=%b want ready=0 resp=1", HREADY, HRESP); else n_pass++;
        exp_addr = LOG ? (clr2 ? 32'h5000_0000 : 32'h3000_0000) : 32'h0;
        n_total++; if (decerr_flag !== LOG) $display("FAIL b2b_flag: got %b want %b", decerr_flag, LOG); else n_pass++;
        n_total++; if (decerr_addr !== exp_addr) $display("FAIL b2b_addr: got %h want %h", decerr_addr, exp_addr); else n_pass++;
        tick();
        n_total++; if (HREADY !== 1'b1 || HRESP !== 1'b1)
            $display("FAIL b2b_err2b: got ready=%b resp=%b want ready=1 resp=1", HREADY, HRESP); else n_pass++;
        tick();
        n_total++; if (HRESP !== 1'b0) $display("FAIL b2b_idle_hresp: got %b want 0", HRESP); else n_pass++;
    endtask

    task automatic test_busy_and_reset();
        pulse_clr();
        HADDR = 32'h3000_0000; HTRANS = 2'b01;
        tick();
        HTRANS = 2'b00; #1;
        n_total++; if (HREADY !== 1'b1 || HRESP !== 1'b0)
            $display("FAIL busy_resp: got ready=%b resp=%b want ready=1 resp=0", HREADY, HRESP); else n_pass++;
        n_total++; if (decerr_flag !== 1'b0) $display("FAIL busy_flag: got %b want 0", decerr_flag); else n_pass++;
        HTRANS = 2'b10;
        tick();
        HTRANS = 2'b00; #1;
        n_total++; if (HREADY !== 1'b0) $display("FAIL rstmid_err1: got %b want 0", HREADY); else n_pass++;
        #2 HRESETn = 1'b0;
        #1;
        n_total++; if (HREADY !== 1'b1 || HRESP !== 1'b0)
            $display("FAIL rstmid_async: got ready=%b resp=%b want ready=1 resp=0", HREADY, HRESP); else n_pass++;
        n_total++; if (decerr_flag !== 1'b0) $display("FAIL rstmid_flag: got %b want 0", decerr_flag); else n_pass++;
        tick();
        HRESETn = 1'b1;
        tick();
        n_total++; if (HREADY !== 1'b1 || HRESP !== 1'b0)
            $display("FAIL rstmid_idle: got ready=%b resp=%b want ready=1 resp=0", HREADY, HRESP); else n_pass++;
    endtask

    task automatic test_dup_tags();
        HADDR2 = 32'h0000_0100; HTRANS2 = 2'b10; #1;
        n_total++; if (HSEL_S2 !== 2'b01) $display("FAIL dup_hsel: got %b want 01", HSEL_S2); else n_pass++;
        tick();
        HTRANS2 = 2'b00; #1;
        n_total++; if (HRDATA2 !== 32'hCAFE_0000) $display("FAIL dup_rdata: got %h want cafe0000", HRDATA2); else n_pass++;
        n_total++; if (HREADY2 !== 1'b1 || HRESP2 !== 1'b0)
            $display("FAIL dup_resp: got ready=%b resp=%b want ready=1 resp=0", HREADY2, HRESP2); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle_decode();
        test_slave_stall();
        test_unmapped();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_busy_and_reset();
        test_dup_tags();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
